// File: rtl/dmem_pkg.sv
// Shared size codes and lane helpers for the data_memory_sync block.
// Helpers work on a wide maximum width; callers cast results down to their own DATA_W.
package dmem_pkg;

    localparam int MAX_DW = 128;
    localparam int MAX_NB = MAX_DW / 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [MAX_NB-1:0] lane_mask(input logic [1:0] msize,
                                                    input int offset,
                                                    input int nb);
        logic [MAX_NB-1:0] m;
        case (msize)
            SZ_B:    m = {{(MAX_NB-1){1'b0}}, 1'b1} << offset;
            SZ_H:    m = {{(MAX_NB-2){1'b0}}, 2'b11} << offset;
            SZ_W:    m = ~({MAX_NB{1'b1}} << nb);
            default: m = {MAX_NB{1'b0}};
        endcase
        return m;
    endfunction

    // Data arrives already shifted down to bit 0.
    function automatic logic [MAX_DW-1:0] ext(input logic [MAX_DW-1:0] data,
                                              input logic [1:0]        msize,
                                              input logic              muns);
        logic [MAX_DW-1:0] r;
        case (msize)
            SZ_B:    r = {{(MAX_DW-8){~muns & data[7]}}, data[7:0]};
            SZ_H:    r = {{(MAX_DW-16){~muns & data[15]}}, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic lane_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane alignment for data_memory_sync: LOAD=0 replicates store data across lanes,
// LOAD=1 shifts the addressed lanes down to bit 0 and extends them.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit LOAD   = 1'b0
) (
    input  logic [DATA_W-1:0]           i_data,
    input  logic [1:0]                  i_size,
    input  logic [$clog2(DATA_W/8)-1:0] i_off,
    input  logic                        i_uns,
    output logic [DATA_W-1:0]           o_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] w_repl;
    logic [DATA_W-1:0] w_shift;

    // Store side: right-justified datum copied into every lane of its size.
    always_comb begin
        case (i_size)
            SZ_B:    w_repl = {NB{i_data[7:0]}};
            SZ_H:    w_repl = {(NB/2){i_data[15:0]}};
            default: w_repl = i_data;
        endcase
    end

    // Load side and output select.
    always_comb begin
        w_shift = i_data >> {i_off, 3'b000};
        if (LOAD) begin
            o_data = DATA_W'(ext(MAX_DW'(w_shift), i_size, i_uns));
        end else begin
            o_data = w_repl;
        end
    end

endmodule

// File: rtl/data_memory_sync.sv
// Clocked byte/half/word data memory with RD_LAT (1 or 2) load latency.
// Defining DMEM_PARITY_EN adds per-lane even parity and the par_inj test input.
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] wd,
    input  logic              mwr,
    input  logic              moe,
    input  logic [1:0]        msize,
    input  logic              muns,
`ifdef DMEM_PARITY_EN
    input  logic              par_inj,
`endif
    output logic [DATA_W-1:0] rd,
    output logic              rd_valid,
    output logic              err
);

    localparam int NB    = DATA_W / 8;
    localparam int LG_NB = $clog2(NB);
    localparam int LG_D  = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LG_D-1:0]   w_idx;
    logic [LG_NB-1:0]  w_off;
    logic              w_oob, w_mis, w_illegal, w_perr, w_err;
    logic [NB-1:0]     w_lmask, w_wmask;
    logic [DATA_W-1:0] w_wdata, w_old, w_merged, w_ldata;
    logic              r_s1_vld, r_s1_err;
    logic [DATA_W-1:0] r_s1_rd;

    assign w_idx = adr[LG_NB+LG_D-1:LG_NB];
    assign w_off = adr[LG_NB-1:0];
    assign w_old = r_mem[w_idx];

    // Legality and lane enables; an illegal access never writes.
    always_comb begin
        w_oob = |adr[ADDR_W-1:LG_NB+LG_D];
        case (msize)
            SZ_B:    w_mis = 1'b0;
            SZ_H:    w_mis = w_off[0];
            SZ_W:    w_mis = |w_off;
            default: w_mis = 1'b1;
        endcase
        w_illegal = w_oob | w_mis;
        w_lmask   = NB'(lane_mask(msize, int'(w_off), NB));
        if (mwr && !w_illegal) begin
            w_wmask = w_lmask;
        end else begin
            w_wmask = {NB{1'b0}};
        end
    end

    dmem_align #(.DATA_W(DATA_W), .LOAD(1'b0)) u_st_align (
        .i_data (wd),
        .i_size (msize),
        .i_off  (w_off),
        .i_uns  (muns),
        .o_data (w_wdata)
    );

    // Write-first: a same-edge load sees the freshly stored lanes.
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (w_wmask[i]) begin
                w_merged[i*8 +: 8] = w_wdata[i*8 +: 8];
            end else begin
                w_merged[i*8 +: 8] = w_old[i*8 +: 8];
            end
        end
    end

    // Array write, per lane; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_wmask[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
    end

    dmem_align #(.DATA_W(DATA_W), .LOAD(1'b1)) u_ld_align (
        .i_data (w_merged),
        .i_size (msize),
        .i_off  (w_off),
        .i_uns  (muns),
        .o_data (w_ldata)
    );

`ifdef DMEM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_npar, w_pmerged, w_pcalc;

    // Parity written alongside each lane; par_inj corrupts it on purpose.
    always_comb begin
        w_npar    = {NB{1'b0}};
        w_pmerged = {NB{1'b0}};
        w_pcalc   = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            w_npar[i]  = lane_par(w_wdata[i*8 +: 8]) ^ par_inj;
            w_pcalc[i] = lane_par(w_merged[i*8 +: 8]);
            if (w_wmask[i]) begin
                w_pmerged[i] = w_npar[i];
            end else begin
                w_pmerged[i] = r_par[w_idx][i];
            end
        end
        w_perr = |(w_lmask & (w_pcalc ^ w_pmerged));
    end

    // Parity array write, same enables as the data lanes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_wmask[i]) r_par[w_idx][i] <= w_npar[i];
        end
    end
`else
    assign w_perr = 1'b0;
`endif

    assign w_err = ((mwr | moe) & w_illegal) | (moe & w_perr);

    // First result stage; rd only moves when a load is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_err <= 1'b0;
            r_s1_rd  <= {DATA_W{1'b0}};
        end else begin
            r_s1_vld <= moe;
            r_s1_err <= w_err;
            if (moe) begin
                r_s1_rd <= w_illegal ? {DATA_W{1'b0}} : w_ldata;
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rd       = r_s1_rd;
        assign rd_valid = r_s1_vld;
        assign err      = r_s1_err;
    end else if (RD_LAT == 2) begin : g_lat2
        logic              r_vld, r_err;
        logic [DATA_W-1:0] r_rd;

        // Extra output register stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_err <= 1'b0;
                r_rd  <= {DATA_W{1'b0}};
            end else begin
                r_vld <= r_s1_vld;
                r_err <= r_s1_err;
                if (r_s1_vld) r_rd <= r_s1_rd;
            end
        end

        assign rd       = r_rd;
        assign rd_valid = r_vld;
        assign err      = r_err;
    end else begin : g_bad_lat
        $error("data_memory_sync: RD_LAT must be 1 or 2");
    end

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench driving identical stimulus into an RD_LAT=1 and an RD_LAT=2 instance.
module tb_data_memory_sync;
    import dmem_pkg::*;

`ifdef DMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        int          due;
        logic        vld;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic        o;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic        p;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic        mwr = 1'b0;
    logic        moe = 1'b0;
    logic [1:0]  msize = 2'b10;
    logic        muns = 1'b0;
    logic        par_inj = 1'b0;
    logic [1:0]  dv, de;
    logic [31:0] dr [2];

    logic [31:0] m_mem [256];
    logic [3:0]  m_pbad [256];
    exp_t        sb [2][$];
    logic [31:0] last_rd [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_memory_sync #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .adr(adr), .wd(wd), .mwr(mwr), .moe(moe),
        .msize(msize), .muns(muns),
`ifdef DMEM_PARITY_EN
        .par_inj(par_inj),
`endif
        .rd(dr[0]), .rd_valid(dv[0]), .err(de[0])
    );

    data_memory_sync #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .adr(adr), .wd(wd), .mwr(mwr), .moe(moe),
        .msize(msize), .muns(muns),
`ifdef DMEM_PARITY_EN
        .par_inj(par_inj),
`endif
        .rd(dr[1]), .rd_valid(dv[1]), .err(de[1])
    );

    function automatic op_t op(input logic w, input logic o, input logic [1:0] sz,
                               input logic u, input logic [31:0] a, input logic [31:0] d,
                               input logic p = 1'b0);
        op_t t;
        t.w = w; t.o = o; t.sz = sz; t.u = u; t.a = a; t.d = d; t.p = p;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Applies one access and records what each instance must produce for it.
    task automatic drive(input op_t t);
        logic        ill;
        logic [3:0]  m;
        logic [31:0] rep, word;
        exp_t        e;
        int          idx, off;
        adr = t.a; wd = t.d; mwr = t.w; moe = t.o; msize = t.sz; muns = t.u; par_inj = t.p;
        off = int'(t.a[1:0]);
        idx = int'(t.a[9:2]);
        ill = (t.sz == 2'b11) || (t.sz == SZ_H && t.a[0]) ||
              (t.sz == SZ_W && t.a[1:0] != 2'b00) || (t.a >= 32'd1024);
        case (t.sz)
            SZ_B:    begin m = 4'b0001 << off; rep = {4{t.d[7:0]}};  end
            SZ_H:    begin m = 4'b0011 << off; rep = {2{t.d[15:0]}}; end
            default: begin m = 4'b1111;        rep = t.d;            end
        endcase
        if (t.w && !ill) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    m_mem[idx][i*8 +: 8] = rep[i*8 +: 8];
                    m_pbad[idx][i] = t.p;
                end
            end
        end
        if (t.o || (t.w && ill)) begin
            word  = m_mem[idx] >> (8 * off);
            e.vld = t.o;
            e.err = ill || (PAR && ((m & m_pbad[idx]) != 4'b0000));
            if (ill)             e.rd = 32'h0;
            else if (t.sz == SZ_B) e.rd = {{24{!t.u && word[7]}}, word[7:0]};
            else if (t.sz == SZ_H) e.rd = {{16{!t.u && word[15]}}, word[15:0]};
            else                 e.rd = word;
            for (int k = 0; k < 2; k++) begin
                e.due = cyc + 1 + k;
                sb[k].push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; moe = 1'b1; msize = SZ_W; adr = 32'h0;
        for (int n = 0; n < 4; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dv[k] !== 1'b0 || de[k] !== 1'b0 || dr[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset lat%0d cyc%0d: got vld=%b err=%b rd=%h, want 0 0 0",
                             k + 1, cyc, dv[k], de[k], dr[k]);
                end
            end
        end
        moe = 1'b0;
        rst_n = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
    endtask

    task automatic run_ops(input string name, input op_t ops[$]);
        exp_t        ex;
        logic [31:0] exp_rd;
        for (int n = 0; n < 3; n++) ops.push_back(op(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0));
        for (int n = 0; n < ops.size(); n++) begin
            drive(ops[n]);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (sb[k].size() > 0 && sb[k][0].due == cyc) ex = sb[k].pop_front();
                else ex = '{due: cyc, vld: 1'b0, err: 1'b0, rd: last_rd[k]};
                exp_rd = ex.vld ? ex.rd : last_rd[k];
                if (dv[k] !== ex.vld || de[k] !== ex.err || dr[k] !== exp_rd) begin
                    errors++;
                    $display("FAIL %s lat%0d cyc%0d: got vld=%b err=%b rd=%h, want vld=%b err=%b rd=%h",
                             name, k + 1, cyc, dv[k], de[k], dr[k], ex.vld, ex.err, exp_rd);
                end
                last_rd[k] = exp_rd;
            end
        end
        checks++;
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d/%0d results still pending, want 0/0",
                     name, sb[0].size(), sb[1].size());
            sb[0].delete();
            sb[1].delete();
        end
    endtask

    task automatic test_store_load();
        op_t ops[$];
        ops.push_back(op(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b0, 32'h13, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b1, 32'h11, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_H, 1'b0, 32'h12, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_H, 1'b0, 32'h20, 32'h00008001));
        ops.push_back(op(1'b0, 1'b1, SZ_H, 1'b1, 32'h22, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_H, 1'b0, 32'h20, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_B, 1'b0, 32'h12, 32'hFFFFFF55));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h0));
        run_ops("store_load", ops);
    endtask

    task automatic test_illegal();
        op_t ops[$];
        ops.push_back(op(1'b1, 1'b0, SZ_W, 1'b0, 32'h00, 32'hA5A5A5A5));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h06, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_W, 1'b0, 32'h400, 32'hFFFFFFFF));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h00, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_H, 1'b0, 32'h01, 32'h0));
        ops.push_back(op(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_B, 1'b0, 32'h3FF, 32'h00000077));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b1, 32'h3FF, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b0, 32'h400, 32'h0));
        run_ops("illegal", ops);
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        ops.push_back(op(1'b1, 1'b1, SZ_W, 1'b0, 32'h30, 32'h12345678));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b1, 32'h30, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b1, 32'h31, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_H, 1'b1, 32'h32, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h30, 32'h0));
        ops.push_back(op(1'b1, 1'b1, SZ_B, 1'b0, 32'h31, 32'h000000AA));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h30, 32'h0));
        run_ops("back_to_back", ops);
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        op_t ops[$];
        ops.push_back(op(1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0F0F0F0F, 1'b1));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h40, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0F0F0F0F, 1'b0));
        ops.push_back(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h40, 32'h0));
        ops.push_back(op(1'b1, 1'b0, SZ_B, 1'b0, 32'h41, 32'h00000033, 1'b1));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b0, 32'h40, 32'h0));
        ops.push_back(op(1'b0, 1'b1, SZ_B, 1'b0, 32'h41, 32'h0));
        run_ops("parity", ops);
    endtask
`endif

    task automatic test_reset_inflight();
        op_t ops[$];
        drive(op(1'b0, 1'b1, SZ_W, 1'b0, 32'h30, 32'h0));
        tick();
        rst_n = 1'b0;
        drive(op(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0));
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dv[k] !== 1'b0 || de[k] !== 1'b0 || dr[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_inflight lat%0d: got vld=%b err=%b rd=%h, want 0 0 0",
                         k + 1, dv[k], de[k], dr[k]);
            end
            sb[k].delete();
            last_rd[k] = 32'h0;
        end
        tick();
        rst_n = 1'b1;
        run_ops("after_reset", ops);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i]  = 32'hx;
            m_pbad[i] = 4'b0000;
        end
        test_reset();
        test_store_load();
        test_illegal();
        test_back_to_back();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
